// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predict unit: branch funct3 codes,
// resolved-outcome encodings and the 2-bit saturating counter states.
package bpu_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      TT_NONE = 2'b00,
      TT_BR   = 2'b01,
      TT_JAL  = 2'b10,
      TT_JALR = 2'b11
   } taken_type_e;

   // Counter MSB is the predicted direction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_state_e;

   // Saturating step of one counter toward the resolved direction.
   function automatic cnt_state_e cnt_next(input cnt_state_e cur, input logic taken);
      cnt_state_e nxt;
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   // funct3 010/011 carry no branch condition.
   function automatic logic br_legal(input logic [2:0] fun3);
      return !((fun3 == 3'b010) || (fun3 == 3'b011));
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predict unit: IF predict port,
// EX resolve port and the registered redirect/status outputs.
interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic            ex_valid;
   logic            ex_branch;
   logic            ex_jal;
   logic            ex_jalr;
   logic [2:0]      ex_fun3;
   logic [XLEN-1:0] ex_rs1;
   logic [XLEN-1:0] ex_rs2;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic            ex_pred_taken;
   logic [1:0]      taken_type;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            illegal_br;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispred;

   // Pipeline side: supplies PCs and EX operands, consumes predictions and redirects.
   modport master (
      output if_pc, ex_valid, ex_branch, ex_jal, ex_jalr, ex_fun3,
             ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
      input  pred_taken, taken_type, redirect, redirect_pc, illegal_br,
             stat_branches, stat_mispred
   );

   // Branch unit side.
   modport slave (
      input  if_pc, ex_valid, ex_branch, ex_jal, ex_jalr, ex_fun3,
             ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
      output pred_taken, taken_type, redirect, redirect_pc, illegal_br,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/bht_counter_array.sv
// Branch history table: DEPTH x 2-bit saturating counters with one
// asynchronous read port (IF prediction) and one synchronous update port (EX).
module bht_counter_array
   import bpu_pkg::*;
#(
   parameter int         DEPTH     = 64,
   parameter logic [1:0] CNT_RESET = 2'b01,
   localparam int        IDX_W     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output cnt_state_e       rd_cnt_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   cnt_state_e table_q [DEPTH];

   // Read returns the stored value, so a same-cycle update to the same index is not visible yet.
   assign rd_cnt_o = table_q[rd_idx_i];

   // Reset every counter to CNT_RESET; otherwise step the addressed counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the whole table is reset in one cycle, so it is built from flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= cnt_state_e'(CNT_RESET);
         end
      end else if (upd_en_i) begin
         table_q[upd_idx_i] <= cnt_next(table_q[upd_idx_i], upd_taken_i);
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: predicts conditional branches in IF from a BHT,
// resolves RV32I branches and JAL/JALR in EX, and issues a registered
// one-cycle redirect on mispredict or jump.
// Optional feature: define BPU_STATS_EN to build the resolved-branch and
// mispredict counters; without it the stat outputs are tied to 0.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         BHT_DEPTH = 64,
   parameter logic [1:0] CNT_RESET = 2'b01
) (
   input logic                 clk,
   input logic                 rst,
   branch_predict_unit_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   taken_type_e     tt_d, tt_q;
   logic            redirect_d, redirect_q;
   logic [XLEN-1:0] redirect_pc_d, redirect_pc_q;
   logic            illegal_d, illegal_q;
   logic            accept;
   logic            br_taken;
   logic            upd_en;
   cnt_state_e      rd_cnt;
   logic            unused_if_pc_bits;

   // Only the word-index bits of the fetch PC address the table.
   assign unused_if_pc_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

   // While a redirect is out, the instruction in EX is wrong-path and ignored.
   assign accept = bus.ex_valid && !redirect_q;

   bht_counter_array #(
      .DEPTH     (BHT_DEPTH),
      .CNT_RESET (CNT_RESET)
   ) u_bht (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (bus.if_pc[IDX_W+1:2]),
      .rd_cnt_o    (rd_cnt),
      .upd_en_i    (upd_en),
      .upd_idx_i   (bus.ex_pc[IDX_W+1:2]),
      .upd_taken_i (br_taken)
   );

   assign bus.pred_taken = rd_cnt[1];

   // Evaluate the branch condition selected by funct3.
   always_comb begin
      // NOTE: default assignment first so every path drives br_taken; a missing branch would infer a latch.
      br_taken = 1'b0;
      case (bus.ex_fun3)
         F3_BEQ:  br_taken = (bus.ex_rs1 == bus.ex_rs2);
         F3_BNE:  br_taken = (bus.ex_rs1 != bus.ex_rs2);
         F3_BLT:  br_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
         F3_BGE:  br_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
         F3_BLTU: br_taken = (bus.ex_rs1 <  bus.ex_rs2);
         F3_BGEU: br_taken = (bus.ex_rs1 >= bus.ex_rs2);
         default: br_taken = 1'b0;
      endcase
   end

   // Resolve the accepted instruction: jalr > jal > branch.
   always_comb begin
      tt_d          = TT_NONE;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      illegal_d     = 1'b0;
      upd_en        = 1'b0;
      if (accept) begin
         if (bus.ex_jalr) begin
            tt_d          = TT_JALR;
            redirect_d    = 1'b1;
            redirect_pc_d = (bus.ex_rs1 + bus.ex_imm) & ~XLEN'(1);
         end else if (bus.ex_jal) begin
            tt_d          = TT_JAL;
            redirect_d    = 1'b1;
            redirect_pc_d = bus.ex_pc + bus.ex_imm;
         end else if (bus.ex_branch) begin
            if (!br_legal(bus.ex_fun3)) begin
               illegal_d = 1'b1;
            end else begin
               upd_en = 1'b1;
               tt_d   = br_taken ? TT_BR : TT_NONE;
               if (br_taken != bus.ex_pred_taken) begin
                  redirect_d    = 1'b1;
                  redirect_pc_d = br_taken ? (bus.ex_pc + bus.ex_imm) : (bus.ex_pc + XLEN'(4));
               end
            end
         end
      end
   end

   // Register the resolution so every output is a one-cycle pulse after accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         tt_q          <= TT_NONE;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state updates from values sampled at the same edge.
         tt_q          <= tt_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         illegal_q     <= illegal_d;
      end
   end

   assign bus.taken_type  = tt_q;
   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.illegal_br  = illegal_q;

`ifdef BPU_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_mispred_q;

   // Count resolved legal branches and their mispredicts, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (upd_en && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_q <= stat_branches_q + 32'd1;
         end
         if (upd_en && redirect_d && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_q <= stat_mispred_q + 32'd1;
         end
      end
   end

   assign bus.stat_branches = stat_branches_q;
   assign bus.stat_mispred  = stat_mispred_q;
`else
   assign bus.stat_branches = '0;
   assign bus.stat_mispred  = '0;
`endif

endmodule
